cv32e40s_alert_escalator: RTL

Downstream consumer of the core's registered alert outputs (`alert_minor`, `alert_major`). It counts minor alerts in a leaky-bucket window and escalates to a major alert when the count reaches a threshold. Major alerts are latched into a sticky escalation flag. Pending alerts are forwarded to an external alert receiver over a four-phase req/ack handshake, with major taking priority over minor.

---
 rtl/cv32e40s_pkg.sv | 16 +
 rtl/cv32e40s_alert_leak_timer.sv | 30 +++
 rtl/cv32e40s_alert_escalator.sv | 116 +++++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// rtl/cv32e40s_pkg.sv - shared types for the alert escalator
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } alert_hs_state_e;

    typedef enum logic [1:0] {
        ALERT_NONE  = 2'b00,
        ALERT_MINOR = 2'b01,
        ALERT_MAJOR = 2'b10
    } alert_class_e;

endpackage

// File: rtl/cv32e40s_alert_leak_timer.sv
// rtl/cv32e40s_alert_leak_timer.sv - free-running wrap counter giving one leak pulse per window
module cv32e40s_alert_leak_timer #(
    parameter int unsigned WINDOW_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic leak_o
);

    localparam int unsigned TW = $clog2(WINDOW_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // The cycle spent at the last count is the leak cycle
    assign leak_o = (cnt == LAST);

endmodule

// File: rtl/cv32e40s_alert_escalator.sv
// rtl/cv32e40s_alert_escalator.sv - minor-alert leaky bucket, sticky escalation and req/ack alert sender
module cv32e40s_alert_escalator
    import cv32e40s_pkg::*;
#(
    parameter  int unsigned MINOR_THRESHOLD = 4,
    parameter  int unsigned WINDOW_CYCLES   = 1024,
    localparam int unsigned CNT_W           = $clog2(MINOR_THRESHOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alert_minor_i,
    input  logic             alert_major_i,
    input  logic             clear_i,
    input  logic             alert_ack_i,
    output logic             alert_req_o,
    output logic [1:0]       alert_class_o,
    output logic             escalate_o,
    output logic [CNT_W-1:0] minor_cnt_o
);

    localparam logic [CNT_W:0] THR = (CNT_W + 1)'(MINOR_THRESHOLD);
    localparam logic [CNT_W:0] ONE = (CNT_W + 1)'(1);

    alert_hs_state_e state, state_nxt;
    alert_class_e    class_q;
    logic            major_pend, minor_pend;
    logic            leak;
    logic [CNT_W:0]  bucket_sum;
    logic [CNT_W-1:0] bucket_nxt;
    logic            threshold_hit, major_set;
    logic            launch_major, launch_minor;

    cv32e40s_alert_leak_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_leak_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .leak_o  (leak)
    );

    // Bucket: one wide sum so increment and leak in one cycle cancel out
    always_comb begin
        bucket_sum = {1'b0, minor_cnt_o};
        if (alert_minor_i) begin
            bucket_sum = bucket_sum + ONE;
        end
        if (leak && (minor_cnt_o != '0)) begin
            bucket_sum = bucket_sum - ONE;
        end
        threshold_hit = !clear_i && (bucket_sum == THR);
        if (clear_i || threshold_hit) begin
            bucket_nxt = '0;
        end else begin
            bucket_nxt = bucket_sum[CNT_W-1:0];
        end
        major_set = alert_major_i || threshold_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            class_q     <= ALERT_NONE;
            major_pend  <= 1'b0;
            minor_pend  <= 1'b0;
            escalate_o  <= 1'b0;
            minor_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            major_pend  <= (major_pend || major_set) && !launch_major;
            minor_pend  <= (minor_pend || alert_minor_i) && !launch_minor;
            escalate_o  <= escalate_o || major_set;
            minor_cnt_o <= bucket_nxt;
            if (launch_major) begin
                class_q <= ALERT_MAJOR;
            end else if (launch_minor) begin
                class_q <= ALERT_MINOR;
            end
        end
    end

    // Events arriving this cycle count as pending so IDLE launches without a bubble
    always_comb begin
        state_nxt    = state;
        launch_major = 1'b0;
        launch_minor = 1'b0;
        case (state)
            IDLE: begin
                if (major_pend || major_set) begin
                    state_nxt    = SEND;
                    launch_major = 1'b1;
                end else if (minor_pend || alert_minor_i) begin
                    state_nxt    = SEND;
                    launch_minor = 1'b1;
                end
            end
            SEND: begin
                if (alert_ack_i) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!alert_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alert_req_o   = (state == SEND);
        alert_class_o = (state == SEND) ? class_q : ALERT_NONE;
    end

endmodule
